// File: rtl/pkt_rr_fifo_arbiter.sv
// Packet-level round-robin arbiter draining NUM_QUEUES non-fallthrough FIFOs
// into one word stream; a grant is held from the first word through EOP.
module pkt_rr_fifo_arbiter #(
  parameter int WIDTH      = 72,
  parameter int NUM_QUEUES = 4,
  parameter int QUEUE_BITS = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_QUEUES-1:0]       in_empty,
  input  logic [NUM_QUEUES*WIDTH-1:0] in_data,
  output logic [NUM_QUEUES-1:0]       in_rd_en,
  output logic [WIDTH-1:0]            out_data,
  output logic                        out_wr,
  output logic [QUEUE_BITS-1:0]       out_queue,
  input  logic                        out_rdy
);

  typedef enum logic {IDLE, READ} state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [QUEUE_BITS-1:0] r_cur;
  logic [QUEUE_BITS-1:0] w_next_cur;
  logic [QUEUE_BITS-1:0] w_idx;
  logic                  r_pend;
  logic                  w_found;
  logic                  w_eop_now;
  logic [NUM_QUEUES-1:0] w_rd_en;
  logic [WIDTH-1:0]      w_slice [NUM_QUEUES];

  for (genvar gi = 0; gi < NUM_QUEUES; gi++) begin : g_slice
    assign w_slice[gi] = in_data[gi*WIDTH +: WIDTH];
  end

  assign w_eop_now = w_slice[r_cur][WIDTH-1];

  always_comb begin
    w_next_state = r_state;
    w_next_cur   = r_cur;
    w_rd_en      = '0;
    w_found      = 1'b0;
    w_idx        = r_cur;
    case (r_state)
      IDLE: begin
        // cur itself is visited last, so a lone active queue is re-granted
        for (int k = 1; k <= NUM_QUEUES; k++) begin
          w_idx = r_cur + QUEUE_BITS'(k);
          if (!w_found && !in_empty[w_idx]) begin
            w_found      = 1'b1;
            w_next_cur   = w_idx;
            w_next_state = READ;
          end
        end
      end
      READ: begin
        // no new read on the cycle the EOP word is being returned
        w_rd_en[r_cur] = ~in_empty[r_cur] & out_rdy & ~(r_pend & w_eop_now);
        if (r_pend && w_eop_now)
          w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cur   <= QUEUE_BITS'(NUM_QUEUES - 1);
      r_pend  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_cur   <= w_next_cur;
      r_pend  <= |w_rd_en;
    end
  end

  assign in_rd_en  = w_rd_en;
  assign out_wr    = r_pend;
  assign out_data  = w_slice[r_cur];
  assign out_queue = r_cur;

endmodule

// File: tb/tb_pkt_rr_fifo_arbiter.sv
// Directed bench for pkt_rr_fifo_arbiter: behavioural upstream FIFOs, per-cycle
// logging of the DUT outputs, and comparison against hand-computed timelines.
module tb_pkt_rr_fifo_arbiter;
  localparam int W = 72;
  localparam int N = 4;
  localparam int L = 32;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   in_empty;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_rd_en;
  logic [W-1:0]   out_data;
  logic           out_wr;
  logic [1:0]     out_queue;
  logic           out_rdy;

  always #5 clk = ~clk;

  pkt_rr_fifo_arbiter #(.WIDTH(W), .NUM_QUEUES(N), .QUEUE_BITS(2)) dut (
    .clk(clk), .reset(reset), .in_empty(in_empty), .in_data(in_data),
    .in_rd_en(in_rd_en), .out_data(out_data), .out_wr(out_wr),
    .out_queue(out_queue), .out_rdy(out_rdy)
  );

  // Upstream FIFO models: dout updates the cycle after rd_en (no fallthrough)
  logic [W-1:0] fq [N][$];
  logic [W-1:0] dout [N];
  for (genvar gi = 0; gi < N; gi++) begin : g_din
    assign in_data[gi*W +: W] = dout[gi];
  end

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  logic [N-1:0] lg_rd [L];
  logic         lg_wr [L];
  logic [1:0]   lg_q  [L];
  logic [W-1:0] lg_d  [L];

  logic [N-1:0] ex_rd  [L];
  logic         ex_wr  [L];
  logic [1:0]   ex_q   [L];
  logic [W-1:0] ex_d   [L];
  logic         ex_chk [L];

  typedef struct {
    logic         rdy;
    logic [N-1:0] rd;
    logic         wr;
    logic [1:0]   q;
    logic [W-1:0] d;
  } vec_t;
  vec_t tbl [7];

  function automatic logic [W-1:0] mkw(int q, int idx, bit eop);
    return {eop, 55'd0, 8'(q), 8'(idx)};
  endfunction

  task automatic check(string nm, logic [W-1:0] got, logic [W-1:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  task automatic upd_empty();
    for (int i = 0; i < N; i++) in_empty[i] = (fq[i].size() == 0);
  endtask

  task automatic push_w(int q, int idx, bit eop);
    fq[q].push_back(mkw(q, idx, eop));
    upd_empty();
  endtask

  task automatic tick();
    logic [N-1:0] s_rd;
    @(negedge clk);
    s_rd = in_rd_en;
    check($sformatf("rd_onehot c%0d", cyc), W'($onehot0(s_rd)), W'(1));
    check($sformatf("rd_of_empty c%0d", cyc), W'(s_rd & in_empty), W'(0));
    if (cyc < L) begin
      lg_rd[cyc] = s_rd;
      lg_wr[cyc] = out_wr;
      lg_q[cyc]  = out_queue;
      lg_d[cyc]  = out_data;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (s_rd[i] && fq[i].size() > 0) dout[i] = fq[i].pop_front();
    upd_empty();
    cyc++;
  endtask

  task automatic clr_exp();
    for (int c = 0; c < L; c++) begin
      ex_rd[c] = '0; ex_wr[c] = 1'b0; ex_q[c] = '0; ex_d[c] = '0; ex_chk[c] = 1'b1;
    end
  endtask

  task automatic set_wr(int c, int q, int idx, bit eop);
    ex_wr[c] = 1'b1;
    ex_q[c]  = 2'(q);
    ex_d[c]  = mkw(q, idx, eop);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    out_rdy = 1'b1;
    for (int i = 0; i < N; i++) begin
      fq[i].delete();
      dout[i] = '0;
    end
    upd_empty();
    cyc = 0;
    tick();
    tick();
    check("reset rd_en", W'(lg_rd[1]), W'(0));
    check("reset out_wr", W'(lg_wr[1]), W'(0));
    reset = 1'b0;
    cyc = 0;
    clr_exp();
  endtask

  task automatic cmp(string nm, int n);
    for (int c = 0; c < n; c++) begin
      if (ex_chk[c]) begin
        check($sformatf("%s c%0d rd_en", nm, c), W'(lg_rd[c]), W'(ex_rd[c]));
        check($sformatf("%s c%0d out_wr", nm, c), W'(lg_wr[c]), W'(ex_wr[c]));
        if (ex_wr[c]) begin
          check($sformatf("%s c%0d out_queue", nm, c), W'(lg_q[c]), W'(ex_q[c]));
          check($sformatf("%s c%0d out_data", nm, c), lg_d[c], ex_d[c]);
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Three-word packet on queue 0: grant at c0, reads c1-c3, writes c2-c4
    tbl[0] = '{1'b1, 4'b0000, 1'b0, 2'd0, '0};
    tbl[1] = '{1'b1, 4'b0001, 1'b0, 2'd0, '0};
    tbl[2] = '{1'b1, 4'b0001, 1'b1, 2'd0, mkw(0, 0, 1'b0)};
    tbl[3] = '{1'b1, 4'b0001, 1'b1, 2'd0, mkw(0, 1, 1'b0)};
    tbl[4] = '{1'b1, 4'b0000, 1'b1, 2'd0, mkw(0, 2, 1'b1)};
    tbl[5] = '{1'b1, 4'b0000, 1'b0, 2'd0, '0};
    tbl[6] = '{1'b1, 4'b0000, 1'b0, 2'd0, '0};

    do_reset();
    push_w(0, 0, 1'b0);
    push_w(0, 1, 1'b0);
    push_w(0, 2, 1'b1);
    for (int i = 0; i < 7; i++) begin
      out_rdy = tbl[i].rdy;
      tick();
      check($sformatf("tbl c%0d rd_en", i), W'(lg_rd[i]), W'(tbl[i].rd));
      check($sformatf("tbl c%0d out_wr", i), W'(lg_wr[i]), W'(tbl[i].wr));
      if (tbl[i].wr) begin
        check($sformatf("tbl c%0d out_queue", i), W'(lg_q[i]), W'(tbl[i].q));
        check($sformatf("tbl c%0d out_data", i), lg_d[i], tbl[i].d);
      end
    end

    // All queues hold a 2-word packet: served 0,1,2,3 with a 4-cycle period
    do_reset();
    for (int q = 0; q < N; q++) begin
      push_w(q, 0, 1'b0);
      push_w(q, 1, 1'b1);
    end
    for (int c = 0; c < 16; c++) begin
      if (c % 4 == 1 || c % 4 == 2) ex_rd[c] = 4'(1 << (c / 4));
      if (c % 4 >= 2) set_wr(c, c / 4, c % 4 - 2, (c % 4) == 3);
    end
    for (int c = 0; c < 20; c++) tick();
    cmp("all4", 20);

    // Queue 2 starves mid-packet; others arrive meanwhile and must wait
    do_reset();
    for (int c = 0; c < 21; c++) begin
      if (c == 0) push_w(2, 0, 1'b0);
      if (c == 2) begin
        push_w(0, 0, 1'b1);
        push_w(1, 0, 1'b1);
        push_w(3, 0, 1'b1);
      end
      if (c == 7) begin
        push_w(2, 1, 1'b0);
        push_w(2, 2, 1'b1);
      end
      tick();
    end
    ex_rd[1] = 4'b0100; ex_rd[7] = 4'b0100; ex_rd[8] = 4'b0100;
    set_wr(2, 2, 0, 1'b0); set_wr(8, 2, 1, 1'b0); set_wr(9, 2, 2, 1'b1);
    ex_rd[11] = 4'b1000; set_wr(12, 3, 0, 1'b1);
    ex_rd[14] = 4'b0001; set_wr(15, 0, 0, 1'b1);
    ex_rd[17] = 4'b0010; set_wr(18, 1, 0, 1'b1);
    cmp("starve", 21);

    // out_rdy low c3-c5 on a 4-word packet
    do_reset();
    for (int w = 0; w < 4; w++) push_w(0, w, w == 3);
    for (int c = 0; c < 11; c++) begin
      out_rdy = !(c >= 3 && c <= 5);
      tick();
    end
    out_rdy = 1'b1;
    ex_rd[1] = 4'b0001; ex_rd[2] = 4'b0001; ex_rd[6] = 4'b0001; ex_rd[7] = 4'b0001;
    set_wr(2, 0, 0, 1'b0); set_wr(3, 0, 1, 1'b0);
    set_wr(7, 0, 2, 1'b0); set_wr(8, 0, 3, 1'b1);
    cmp("backpr", 11);

    // Two single-word packets on queue 1 only
    do_reset();
    push_w(1, 0, 1'b1);
    push_w(1, 1, 1'b1);
    for (int c = 0; c < 8; c++) tick();
    ex_rd[1] = 4'b0010; ex_rd[4] = 4'b0010;
    set_wr(2, 1, 0, 1'b1); set_wr(5, 1, 1, 1'b1);
    cmp("single", 8);

    // Reset during word 2 of a queue-3 packet; queue 0 then wins arbitration
    do_reset();
    for (int w = 0; w < 4; w++) push_w(3, w, w == 3);
    for (int c = 0; c < 12; c++) begin
      if (c == 3) begin
        reset = 1'b1;
        push_w(0, 0, 1'b1);
      end
      if (c == 4) reset = 1'b0;
      tick();
    end
    ex_rd[1] = 4'b1000; ex_rd[2] = 4'b1000;
    set_wr(2, 3, 0, 1'b0);
    ex_chk[3] = 1'b0;
    ex_rd[5] = 4'b0001; set_wr(6, 0, 0, 1'b1);
    ex_rd[8] = 4'b1000; set_wr(9, 3, 3, 1'b1);
    cmp("midrst", 12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
